// File: rtl/reg_sw_bus_master.sv
// Master end of the 8-way register switch: sequences sel/dir, turnaround, bus drive and sample.
// Optional write-verify readback path is compiled in with REG_SW_WR_VERIFY_EN.
module reg_sw_bus_master #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SW          = 3,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned WR_HOLD     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [SW-1:0] req_sel,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [SW-1:0] sw_sel,
  output logic          sw_dir,
  inout  wire  [DW-1:0] sw_bus
);

  localparam int unsigned MaxCnt   = (TURN_CYCLES > WR_HOLD) ? TURN_CYCLES : WR_HOLD;
  localparam int unsigned CW       = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam logic [CW-1:0] TurnLoad = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] HoldLoad = CW'(WR_HOLD - 1);

`ifdef REG_SW_WR_VERIFY_EN
  typedef enum logic [3:0] {
    StIdle, StSetup, StTurn, StWrite, StRead, StResp, StVdir, StVturn, StVread
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StSetup, StTurn, StWrite, StRead, StResp
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sw_sel_q, sw_sel_d;
  logic            sw_dir_q, sw_dir_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
`ifdef REG_SW_WR_VERIFY_EN
  logic            err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sw_sel_q <= '0;
      sw_dir_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef REG_SW_WR_VERIFY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_sel_q <= sw_sel_d;
      sw_dir_q <= sw_dir_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef REG_SW_WR_VERIFY_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sw_sel_d = sw_sel_q;
    sw_dir_d = sw_dir_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef REG_SW_WR_VERIFY_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        // sel/dir settle during SETUP while the bus stays released
        if (req_valid) begin
          state_d  = StSetup;
          sw_sel_d = req_sel;
          sw_dir_d = req_we;
          wdata_d  = req_wdata;
        end
      end
      StSetup: begin
        state_d = StTurn;
        cnt_d   = TurnLoad;
      end
      StTurn: begin
        if (cnt_q == '0) begin
          if (sw_dir_q) begin
            state_d = StWrite;
            cnt_d   = HoldLoad;
          end else begin
            state_d = StRead;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StWrite: begin
        if (cnt_q == '0) begin
          // Bus is released on the same edge that dir drops back to reg->bus
          sw_dir_d = 1'b0;
`ifdef REG_SW_WR_VERIFY_EN
          state_d  = StVdir;
`else
          state_d  = StResp;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StRead: begin
        rdata_d = sw_bus;
`ifdef REG_SW_WR_VERIFY_EN
        err_d   = 1'b0;
`endif
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
`ifdef REG_SW_WR_VERIFY_EN
      StVdir: begin
        state_d = StVturn;
        cnt_d   = TurnLoad;
      end
      StVturn: begin
        if (cnt_q == '0) begin
          state_d = StVread;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StVread: begin
        rdata_d = sw_bus;
        err_d   = (sw_bus != wdata_q);
        state_d = StResp;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign sw_sel    = sw_sel_q;
  assign sw_dir    = sw_dir_q;
  assign sw_bus    = (state_q == StWrite) ? wdata_q : {DW{1'bz}};
`ifdef REG_SW_WR_VERIFY_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_sw_bus_master.sv
// Directed plus random transactions against a register-file/switch model and a timing model
// derived from the latency rules; released bus reads back as all-ones through a pullup.
module tb_reg_sw_bus_master;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned T  = 1;
  localparam int unsigned W  = 2;
  localparam logic [7:0]  Rel = 8'hFF;
`ifdef REG_SW_WR_VERIFY_EN
  localparam bit Verify = 1'b1;
`else
  localparam bit Verify = 1'b0;
`endif
  localparam logic [7:0] Init [8] = '{8'h11, 8'h22, 8'h33, 8'hFD, 8'h44, 8'h55, 8'h66, 8'h77};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [SW-1:0] req_sel = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, sw_dir;
  logic [DW-1:0] rsp_rdata;
  logic [SW-1:0] sw_sel;
  wire  [DW-1:0] sw_bus;

  // Switch + register file model
  logic          drv_en = 1'b0;
  logic          corrupt = 1'b0;
  logic [7:0]    regs [8] = Init;

  // Reference state
  logic [7:0]    exp_regs [8];
  logic [7:0]    exp_rdata;
  int            checks = 0;
  int            errors = 0;

  logic          nxt_pending = 1'b0;
  logic          nxt_we = 1'b0;
  logic [2:0]    nxt_sel = '0;
  logic [7:0]    nxt_wd = '0;

  always #5 clk = ~clk;

  pullup (sw_bus);
  assign sw_bus = (drv_en && !sw_dir) ? regs[sw_sel] : 8'bz;
  always @(posedge clk) if (sw_dir) regs[sw_sel] <= sw_bus ^ {7'd0, corrupt};

  reg_sw_bus_master #(
    .DW         (DW),
    .SW         (SW),
    .TURN_CYCLES(T),
    .WR_HOLD    (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_sel  (req_sel),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .sw_sel   (sw_sel),
    .sw_dir   (sw_dir),
    .sw_bus   (sw_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction, checked cycle by cycle from the accept edge to the idle cycle after RESP.
  task automatic txn(input logic we, input logic [2:0] sel, input logic [7:0] wd, input bit chained);
    int         lat;
    logic [7:0] stored;
    lat    = we ? (T + W + 2 + (Verify ? T + 2 : 0)) : (T + 3);
    stored = wd ^ {7'd0, corrupt};
    if (!chained) begin
      @(negedge clk);
      chk("idle_ready", req_ready, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_sel   = sel;
      req_wdata = wd;
    end
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      if (k == 1) begin
        if (nxt_pending) begin
          req_we      = nxt_we;
          req_sel     = nxt_sel;
          req_wdata   = nxt_wd;
          nxt_pending = 1'b0;
        end else begin
          req_valid = 1'b0;
        end
      end
      // Register side drives the bus in the cycle before the response is due
      drv_en = (!we || Verify) && (k == lat - 1);
      #1;
      chk("busy_ready", req_ready, 0);
      chk("rsp_valid", rsp_valid, k == lat);
      if (k >= 2) chk("sw_sel", sw_sel, sel);
      if (!we) chk("rd_dir", sw_dir, 0);
      else if (k >= 2 && k <= T + W + 1) chk("wr_dir", sw_dir, 1);
      else if (k == lat - 1) chk("vread_dir", sw_dir, 0);
      if (!drv_en) chk("bus", sw_bus, (we && k >= T + 2 && k <= T + W + 1) ? wd : Rel);
      if (k == lat) begin
        if (we) exp_regs[sel] = stored;
        exp_rdata = !we ? exp_regs[sel] : (Verify ? stored : exp_rdata);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, we && Verify && (stored != wd));
      end
    end
    @(posedge clk);
    #1 drv_en = 1'b0;
    #1;
    chk("after_ready", req_ready, 1);
    chk("after_valid", rsp_valid, 0);
    chk("after_dir", sw_dir, 0);
    chk("after_bus", sw_bus, Rel);
    chk("sel_hold", sw_sel, sel);
  endtask

  initial begin
    logic       r_we;
    logic [2:0] r_sel;
    logic [7:0] r_wd;
    exp_regs  = Init;
    exp_rdata = 8'h00;

    // Reset state
    #12;
    chk("rst_bus", sw_bus, Rel);
    chk("rst_dir", sw_dir, 0);
    chk("rst_sel", sw_sel, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed read and write
    txn(1'b0, 3'd3, 8'h00, 1'b0);
    txn(1'b1, 3'd4, 8'h30, 1'b0);
    txn(1'b0, 3'd4, 8'h00, 1'b0);

    // Back-to-back: read queued with req_valid held through the write
    nxt_pending = 1'b1;
    nxt_we      = 1'b0;
    nxt_sel     = 3'd2;
    nxt_wd      = 8'h00;
    txn(1'b1, 3'd6, 8'hAE, 1'b0);
    txn(1'b0, 3'd2, 8'h00, 1'b1);

    // Reset in the first WRITE cycle
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_sel   = 3'd7;
    req_wdata = 8'h3C;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (T + 1) @(posedge clk);
    #2;
    chk("midwr_bus", sw_bus, 8'h3C);
    rst_n = 1'b0;
    #1;
    chk("midrst_bus", sw_bus, Rel);
    chk("midrst_dir", sw_dir, 0);
    chk("midrst_sel", sw_sel, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2 chk("midrst_no_rsp", rsp_valid, 0);
    end
    chk("midrst_rdata", rsp_rdata, exp_rdata);
    txn(1'b1, 3'd7, 8'h0F, 1'b0);
    txn(1'b0, 3'd7, 8'h00, 1'b0);

`ifdef REG_SW_WR_VERIFY_EN
    corrupt = 1'b0;
    txn(1'b1, 3'd5, 8'h5A, 1'b0);
    corrupt = 1'b1;
    txn(1'b1, 3'd5, 8'h5A, 1'b0);
    corrupt = 1'b0;
    txn(1'b0, 3'd5, 8'h00, 1'b0);
`endif

    // Random traffic, occasionally with a corrupting register file
    for (int n = 0; n < 24; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_sel   = 3'($urandom_range(0, 7));
      r_wd    = 8'($urandom);
      corrupt = ($urandom_range(0, 3) == 0);
      txn(r_we, r_sel, r_wd, 1'b0);
    end
    corrupt = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
